// File: rtl/bit_deserializer.sv
// bit_deserializer
//   Assembles a WIDTH-bit word from indexed single-bit beats. Each accepted
//   beat deposits in_bit at position in_index of an internal buffer and bumps
//   a beat counter. The word closes when in_last is seen or the WIDTH-th beat
//   arrives. The word is then presented on out_word/out_count until the
//   consumer takes it.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers a bit beat
//   in_ready   block accepts a beat this cycle (FILL state)
//   in_bit     data bit to deposit
//   in_index   destination bit position (POW bits)
//   in_last    beat closes the word early
//   out_valid  out_word/out_count hold a completed word (HOLD state)
//   out_ready  consumer takes the completed word
//   out_word   assembled word
//   out_count  number of beats accepted for out_word (CW bits)
module bit_deserializer #(
    parameter int WIDTH = 32,
    localparam int POW  = $clog2(WIDTH),
    localparam int CW   = POW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [POW-1:0]   in_index,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [CW-1:0]    out_count
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_word_q;
    logic [CW-1:0]    out_count_q;
    logic             close;

    // Buffer with the current beat merged in. Indices at or above WIDTH
    // (possible only for non-power-of-two WIDTH) match no bit and leave the
    // buffer untouched, but the beat still counts.
    always_comb begin
        word_d = word_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_index == POW'(i)) word_d[i] = in_bit;
        end
        cnt_d = cnt_q + 1'b1;
        close = in_last || (cnt_d == CW'(WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            word_q      <= '0;
            cnt_q       <= '0;
            out_word_q  <= '0;
            out_count_q <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    // in_ready is 1 throughout FILL, so in_valid alone accepts
                    if (in_valid) begin
                        if (close) begin
                            state_q     <= HOLD;
                            out_word_q  <= word_d;
                            out_count_q <= cnt_d;
                        end else begin
                            word_q <= word_d;
                            cnt_q  <= cnt_d;
                        end
                    end
                end
                HOLD: begin
                    // Clear on exit so the next word starts from all zeros
                    if (out_ready) begin
                        state_q <= FILL;
                        word_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_word  = out_word_q;
    assign out_count = out_count_q;

endmodule
